// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// halt/interrupt FSM states and the NOP word loaded into IF/ID on a squash.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    H_RUN    = 2'd0,
    H_DRAIN  = 2'd1,
    H_HALTED = 2'd2
  } halt_state_e;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_WAIT = 2'd1,
    I_ACK  = 2'd2,
    I_HOLD = 2'd3
  } int_state_e;

  localparam logic [15:0] NOP_INSN = 16'h1000;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward selector: picks MEM over WB for a valid source register;
// loads still in MEM cannot forward because their data is not ready yet.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              rs_vld_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic              mem_ld_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_we_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (rs_vld_i) begin
      if (mem_we_i && !mem_ld_i && (rs_i == mem_rd_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_we_i && (rs_i == wb_rd_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline control for the 5-stage core: load-use stall, redirect
// flush, operand forwarding (HAZ_FWD_EN), drain-based halt and interrupt accept.
//
// halt FSM   | meaning
// H_RUN      | normal execution
// H_DRAIN    | halt seen, MEM/WB draining, fetch frozen
// H_HALTED   | core stopped until reset
//
// int FSM    | meaning
// I_IDLE     | no request pending
// I_WAIT     | request seen, holding fetch until no redirect / load stall
// I_ACK      | one-cycle accept: ack IPU, fetch takes vector
// I_HOLD     | waiting for the request level to drop
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int LOAD_LAT   = 1,
  parameter int HALT_DRAIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic              id_rs_a_vld,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_rs_b_vld,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic              mem_ld,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  logic              ex_redirect,
  input  logic              ex_halt,
  input  logic              ipu_int,
  output logic              stall_if,
  output logic              bubble_id,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              int_ack,
  output logic              int_redirect,
  output logic              halted
);

  localparam int LDW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int DRW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [LDW-1:0] LD_INIT    = LDW'(LOAD_LAT - 1);
  localparam logic [DRW-1:0] DRAIN_INIT = DRW'(HALT_DRAIN - 1);

  logic [LDW-1:0] ld_cnt_q, ld_cnt_d;
  logic [DRW-1:0] drain_q, drain_d;
  halt_state_e    halt_q, halt_d;
  int_state_e     int_q, int_d;

  logic ld_hit, raw_hit, lu_stall;
  logic h_stall, h_flush_ifid, h_flush_idex, h_halted;
  logic i_stall, i_flush_ifid, i_ack;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  assign ld_hit = ex_ld && ex_we &&
                  ((id_rs_a_vld && (id_rs_a == ex_rd)) ||
                   (id_rs_b_vld && (id_rs_b == ex_rd)));

`ifdef HAZ_FWD_EN
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i     (id_rs_a),
    .rs_vld_i (id_rs_a_vld),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_we),
    .mem_ld_i (mem_ld),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_we),
    .sel_o    (fwd_a_sel)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i     (id_rs_b),
    .rs_vld_i (id_rs_b_vld),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_we),
    .mem_ld_i (mem_ld),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_we),
    .sel_o    (fwd_b_sel)
  );

  assign raw_hit = 1'b0;
`else
  // Without forwarding every in-flight producer of a read source must retire first.
  logic a_raw, b_raw, unused_mem_ld;

  assign a_raw = id_rs_a_vld && ((ex_we  && (id_rs_a == ex_rd))  ||
                                 (mem_we && (id_rs_a == mem_rd)) ||
                                 (wb_we  && (id_rs_a == wb_rd)));
  assign b_raw = id_rs_b_vld && ((ex_we  && (id_rs_b == ex_rd))  ||
                                 (mem_we && (id_rs_b == mem_rd)) ||
                                 (wb_we  && (id_rs_b == wb_rd)));
  assign raw_hit       = a_raw || b_raw;
  assign fwd_a_sel     = FWD_RF;
  assign fwd_b_sel     = FWD_RF;
  assign unused_mem_ld = mem_ld;
`endif

  assign lu_stall = (ld_hit || (ld_cnt_q != '0) || raw_hit) && !ex_redirect;

  always_comb begin
    ld_cnt_d = '0;
    if (ex_redirect) begin
      ld_cnt_d = '0;
    end else if (ld_cnt_q != '0) begin
      ld_cnt_d = ld_cnt_q - 1'b1;
    end else if (ld_hit) begin
      ld_cnt_d = LD_INIT;
    end
  end

  always_comb begin
    halt_d       = halt_q;
    drain_d      = drain_q;
    h_stall      = 1'b0;
    h_flush_ifid = 1'b0;
    h_flush_idex = 1'b0;
    h_halted     = 1'b0;
    case (halt_q)
      H_RUN: begin
        if (ex_halt) begin
          halt_d       = H_DRAIN;
          drain_d      = DRAIN_INIT;
          h_stall      = 1'b1;
          h_flush_ifid = 1'b1;
          h_flush_idex = 1'b1;
        end
      end
      H_DRAIN: begin
        h_stall      = 1'b1;
        h_flush_ifid = 1'b1;
        // Counter reaching zero on this decrement ends the drain.
        if (drain_q <= DRW'(1)) begin
          drain_d = '0;
          halt_d  = H_HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      H_HALTED: begin
        h_stall      = 1'b1;
        h_flush_ifid = 1'b1;
        h_halted     = 1'b1;
      end
      default: halt_d = H_RUN;
    endcase
  end

  always_comb begin
    int_d        = int_q;
    i_stall      = 1'b0;
    i_flush_ifid = 1'b0;
    i_ack        = 1'b0;
    case (int_q)
      I_IDLE: begin
        if (ipu_int && (halt_q == H_RUN) && !ex_halt) int_d = I_WAIT;
      end
      I_WAIT: begin
        i_stall = 1'b1;
        if (ex_halt) begin
          int_d = I_IDLE;
        end else if (!ex_redirect && (ld_cnt_q == '0)) begin
          int_d = I_ACK;
        end
      end
      I_ACK: begin
        if (ex_halt) begin
          int_d = I_IDLE;
        end else begin
          i_ack        = 1'b1;
          i_flush_ifid = 1'b1;
          int_d        = I_HOLD;
        end
      end
      I_HOLD: begin
        if (ex_halt || !ipu_int) int_d = I_IDLE;
      end
      default: int_d = I_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt_q <= '0;
      drain_q  <= '0;
      halt_q   <= H_RUN;
      int_q    <= I_IDLE;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      drain_q  <= drain_d;
      halt_q   <= halt_d;
      int_q    <= int_d;
    end
  end

  // Combinational hazard terms are masked so every output is 0 while in reset.
  assign stall_if     = rst && (lu_stall || h_stall || i_stall);
  assign bubble_id    = rst && lu_stall;
  assign flush_ifid   = rst && (ex_redirect || h_flush_ifid || i_flush_ifid);
  assign flush_idex   = rst && (ex_redirect || h_flush_idex);
  assign fwd_a        = rst ? fwd_a_sel : FWD_RF;
  assign fwd_b        = rst ? fwd_b_sel : FWD_RF;
  assign int_ack      = rst && i_ack;
  assign int_redirect = rst && i_ack;
  assign halted       = rst && h_halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: LOAD_LAT=3 main instance plus a LOAD_LAT=1 instance;
// expectations follow HAZ_FWD_EN when it is defined for the build.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs_a, id_rs_b, ex_rd, mem_rd, wb_rd;
  logic       id_rs_a_vld, id_rs_b_vld, ex_we, ex_ld, mem_we, mem_ld, wb_we;
  logic       ex_redirect, ex_halt, ipu_int;

  logic       stall_if, bubble_id, flush_ifid, flush_idex, int_ack, int_redirect, halted;
  logic [1:0] fwd_a, fwd_b;

  logic       l1_stall;
  logic       l1_unused_bub, l1_unused_fi, l1_unused_fx, l1_unused_ack, l1_unused_ir, l1_unused_hl;
  logic [1:0] l1_unused_fa, l1_unused_fb;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(3), .LOAD_LAT(3), .HALT_DRAIN(2)) u_dut (
    .clk(clk), .rst(rst),
    .id_rs_a(id_rs_a), .id_rs_a_vld(id_rs_a_vld), .id_rs_b(id_rs_b), .id_rs_b_vld(id_rs_b_vld),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_ld(ex_ld),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_ld(mem_ld),
    .wb_rd(wb_rd), .wb_we(wb_we),
    .ex_redirect(ex_redirect), .ex_halt(ex_halt), .ipu_int(ipu_int),
    .stall_if(stall_if), .bubble_id(bubble_id), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .int_ack(int_ack), .int_redirect(int_redirect), .halted(halted)
  );

  pipe_hazard_ctrl #(.REG_AW(3), .LOAD_LAT(1), .HALT_DRAIN(2)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .id_rs_a(id_rs_a), .id_rs_a_vld(id_rs_a_vld), .id_rs_b(id_rs_b), .id_rs_b_vld(id_rs_b_vld),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_ld(ex_ld),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_ld(mem_ld),
    .wb_rd(wb_rd), .wb_we(wb_we),
    .ex_redirect(ex_redirect), .ex_halt(ex_halt), .ipu_int(ipu_int),
    .stall_if(l1_stall), .bubble_id(l1_unused_bub), .flush_ifid(l1_unused_fi), .flush_idex(l1_unused_fx),
    .fwd_a(l1_unused_fa), .fwd_b(l1_unused_fb), .int_ack(l1_unused_ack), .int_redirect(l1_unused_ir),
    .halted(l1_unused_hl)
  );

  typedef struct {
    string      tag;
    logic [10:0] vec;
    logic       chk_l1;
    logic       l1_st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  // Output vector layout: {stall bubble}_{flush_ifid flush_idex}_{fwd_a}_{fwd_b}_{ack irq_redir halted}
  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [10:0] v, input logic cl1, input logic l1);
    exp_t e;
    e.tag = tag; e.vec = v; e.chk_l1 = cl1; e.l1_st = l1;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    e = sb.pop_front();
    check_eq(e.tag, {stall_if, bubble_id, flush_ifid, flush_idex, fwd_a, fwd_b,
                     int_ack, int_redirect, halted}, e.vec);
    if (e.chk_l1) check_eq({e.tag, "_l1"}, {10'b0, l1_stall}, {10'b0, e.l1_st});
  endtask

  task automatic cyc(input string tag, input logic [10:0] v,
                     input logic cl1 = 1'b0, input logic l1 = 1'b0);
    push_exp(tag, v, cl1, l1);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs_a = '0; id_rs_a_vld = 1'b0; id_rs_b = '0; id_rs_b_vld = 1'b0;
    ex_rd = '0; ex_we = 1'b0; ex_ld = 1'b0;
    mem_rd = '0; mem_we = 1'b0; mem_ld = 1'b0;
    wb_rd = '0; wb_we = 1'b0;
    ex_redirect = 1'b0; ex_halt = 1'b0; ipu_int = 1'b0;
  endtask

  task automatic lu_drive();
    ex_ld = 1'b1; ex_we = 1'b1; ex_rd = 3'd3; id_rs_a = 3'd3; id_rs_a_vld = 1'b1;
  endtask

  localparam logic [10:0] Z    = 11'b00_00_00_00_000;
  localparam logic [10:0] STB  = 11'b11_00_00_00_000;
  localparam logic [10:0] ST   = 11'b10_00_00_00_000;
  localparam logic [10:0] FLB  = 11'b00_11_00_00_000;
  localparam logic [10:0] ACK  = 11'b00_10_00_00_110;
  localparam logic [10:0] HFL  = 11'b10_11_00_00_000;
  localparam logic [10:0] DRN  = 11'b10_10_00_00_000;
  localparam logic [10:0] HLT  = 11'b10_10_00_00_001;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    rst = 1'b0;
    ex_redirect = 1'b1; ex_halt = 1'b1; ipu_int = 1'b1;
    id_rs_a = 3'd3; id_rs_a_vld = 1'b1; wb_we = 1'b1; wb_rd = 3'd3;
    @(posedge clk); #1;
    cyc("reset", Z, 1'b1, 1'b0);
    clear_in();
    rst = 1'b1;

    // load-use: 3 cycles on main instance, 1 on LOAD_LAT=1 instance
    lu_drive();
    cyc("lu_hit", STB, 1'b1, 1'b1);
    ex_ld = 1'b0; ex_we = 1'b0; ex_rd = '0;
    cyc("lu_c1", STB, 1'b1, 1'b0);
    cyc("lu_c2", STB, 1'b1, 1'b0);
    cyc("lu_end", Z, 1'b1, 1'b0);

    // forwarding / non-forwarding stalls
    clear_in();
    mem_we = 1'b1; mem_rd = 3'd5; wb_we = 1'b1; wb_rd = 3'd5; id_rs_b = 3'd5; id_rs_b_vld = 1'b1;
    cyc("fwd_mem", FWD ? 11'b00_00_00_01_000 : STB, 1'b1, !FWD);
    mem_ld = 1'b1;
    cyc("fwd_memld", FWD ? 11'b00_00_00_10_000 : STB, 1'b1, !FWD);
    id_rs_b_vld = 1'b0;
    cyc("fwd_inv", Z, 1'b1, 1'b0);
    clear_in();
    ex_we = 1'b1; ex_rd = 3'd4; id_rs_a = 3'd4; id_rs_a_vld = 1'b1;
    mem_we = 1'b1; mem_rd = 3'd6; wb_we = 1'b1; wb_rd = 3'd4; id_rs_b = 3'd6; id_rs_b_vld = 1'b1;
    cyc("fwd_ab", FWD ? 11'b00_00_10_01_000 : STB, 1'b1, !FWD);
    clear_in();
    mem_we = 1'b1; mem_rd = 3'd0; id_rs_a = 3'd0; id_rs_a_vld = 1'b1;
    cyc("fwd_r0", FWD ? 11'b00_00_01_00_000 : STB, 1'b1, !FWD);
    clear_in();
    wb_we = 1'b1; wb_rd = 3'd2; id_rs_a = 3'd2; id_rs_a_vld = 1'b1;
    cyc("wb_only", FWD ? 11'b00_00_10_00_000 : STB, 1'b1, !FWD);
    wb_we = 1'b0;
    cyc("wb_gone", Z, 1'b1, 1'b0);

    // redirect beats load-use
    clear_in();
    lu_drive(); ex_redirect = 1'b1;
    cyc("rd_lu", FLB, 1'b1, 1'b0);
    clear_in();
    cyc("rd_after", Z, 1'b1, 1'b0);
    lu_drive();
    cyc("lu2_hit", STB, 1'b1, 1'b1);
    clear_in(); ex_redirect = 1'b1;
    cyc("rd_mid", FLB, 1'b1, 1'b0);
    ex_redirect = 1'b0;
    cyc("rd_mid_after", Z, 1'b1, 1'b0);

    // interrupt held across a 3-cycle load stall
    lu_drive(); ipu_int = 1'b1;
    cyc("int_c0", STB, 1'b1, 1'b1);
    ex_ld = 1'b0; ex_we = 1'b0; ex_rd = '0;
    cyc("int_c1", STB);
    cyc("int_c2", STB);
    cyc("int_c3", ST);
    cyc("int_ack", ACK);
    cyc("int_hold1", Z);
    cyc("int_hold2", Z);
    ipu_int = 1'b0;
    cyc("int_fall", Z);
    ipu_int = 1'b1;
    cyc("int_rise", Z);
    cyc("int_wait2", ST);
    cyc("int_ack2", ACK);
    ipu_int = 1'b0;
    cyc("int_idle", Z, 1'b1, 1'b0);

    // redirect delays the accept
    clear_in(); ipu_int = 1'b1;
    cyc("ir_req", Z);
    ex_redirect = 1'b1;
    cyc("ir_wait_rd", HFL);
    ex_redirect = 1'b0;
    cyc("ir_wait", ST);
    cyc("ir_ack", ACK);
    ipu_int = 1'b0;
    cyc("ir_done", Z, 1'b1, 1'b0);

    // halt while interrupt waiting: no ack, halt completes
    ipu_int = 1'b1;
    cyc("hw_req", Z);
    ex_halt = 1'b1;
    cyc("hw_halt", HFL);
    ex_halt = 1'b0;
    cyc("hw_drain", DRN);
    cyc("hw_halted", HLT);
    cyc("hw_sticky", HLT, 1'b1, 1'b1);
    rst = 1'b0;
    #2;
    push_exp("hw_rst", Z, 1'b1, 1'b0);
    sample();
    @(posedge clk); #1;
    clear_in(); rst = 1'b1;

    // halt with simultaneous redirect, halt wins
    ex_halt = 1'b1; ex_redirect = 1'b1;
    cyc("h_c1", HFL, 1'b1, 1'b1);
    clear_in();
    cyc("h_c2", DRN, 1'b1, 1'b1);
    cyc("h_c3", HLT, 1'b1, 1'b1);
    cyc("h_stay", HLT);
    ipu_int = 1'b1;
    cyc("h_noint", HLT);
    cyc("h_noint2", HLT);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_in(); rst = 1'b1;

    // reset during drain clears everything immediately
    ex_halt = 1'b1;
    cyc("h2_c1", HFL);
    ex_halt = 1'b0;
    rst = 1'b0;
    #2;
    push_exp("rst_drain", Z, 1'b1, 1'b0);
    sample();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc("post_rst", Z, 1'b1, 1'b0);
    lu_drive();
    cyc("post_lu", STB, 1'b1, 1'b1);
    clear_in();
    cyc("post_lu_c1", STB, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Centralised, parametrised hazard and pipeline-control unit for the 5-stage core (IF/ID/EX/MEM/WB). It replaces the ad-hoc load-use stall, flush gating and forwarding logic scattered through the core top. It generalises that logic to multi-cycle load latency and configurable register-address width. It adds a drain-based halt FSM and an interrupt accept/ack handshake FSM.

Parameters:
REG_AW, 3, register-address width (2**REG_AW architectural registers)
LOAD_LAT, 1, stall cycles a load-use hazard costs (>=1)
HALT_DRAIN, 2, cycles after halt detection before halted asserts (MEM+WB drain)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
id_rs_a  in  REG_AW  ID source A
id_rs_a_vld  in  1  source A is read
id_rs_b  in  REG_AW  ID source B
id_rs_b_vld  in  1  source B is read
ex_rd  in  REG_AW  EX destination
ex_we  in  1  EX writes a register
ex_ld  in  1  EX is a load
mem_rd  in  REG_AW  MEM destination
mem_we  in  1  MEM writes a register
mem_ld  in  1  MEM is a load
wb_rd  in  REG_AW  WB destination
wb_we  in  1  WB writes a register
ex_redirect  in  1  taken branch/jump resolved in EX
ex_halt  in  1  halt instruction in EX
ipu_int  in  1  level interrupt request from IPU
stall_if  out  1  hold PC and IF/ID
bubble_id  out  1  insert NOP into ID/EX
flush_ifid  out  1  squash IF/ID (load 16'h1000 NOP)
flush_idex  out  1  squash ID/EX
fwd_a  out  2  operand A select: 00 regfile, 01 MEM, 10 WB
fwd_b  out  2  operand B select, same encoding
int_ack  out  1  one-cycle accept pulse to IPU
int_redirect  out  1  fetch takes interrupt vector this cycle
halted  out  1  sticky, core stopped

Behaviour:
- Reset (rst=0, async): all FSMs idle, counters 0, every output 0.
- Load-use: hit = ex_ld & ex_we & ((id_rs_a_vld & id_rs_a==ex_rd) | (id_rs_b_vld & id_rs_b==ex_rd)).
  - On hit: stall_if=bubble_id=1 that cycle (combinational); ld_cnt <= LOAD_LAT-1.
  - While ld_cnt!=0: stall_if=bubble_id=1; ld_cnt decrements.
  - Total stall = LOAD_LAT cycles. LOAD_LAT=1 gives the single-cycle stall of the current core.
- Forwarding (combinational, per operand): MEM match (mem_we & !mem_ld & rs==mem_rd) -> 01; else WB match (wb_we & rs==wb_rd) -> 10; else 00. MEM has priority over WB. Invalid source -> 00. No hardwired-zero register.
- Redirect: ex_redirect -> flush_ifid=flush_idex=1 the same cycle. Redirect beats load-use: bubble/stall suppressed, ld_cnt cleared.
- Halt FSM RUN/DRAIN/HALTED:
  - RUN -> DRAIN on ex_halt. That cycle: flush_ifid=flush_idex=1, stall_if=1. drain_cnt <= HALT_DRAIN-1.
  - DRAIN: stall_if=1, flush_ifid=1, decrement; at 0 -> HALTED.
  - HALTED: halted=1, stall_if=1, flush_ifid=1 until reset.
  - ex_halt with ex_redirect in the same cycle: halt wins.
- Interrupt FSM IDLE/WAIT/ACK/HOLD:
  - IDLE -> WAIT when ipu_int=1 and halt FSM is RUN.
  - WAIT: stall_if=1. -> ACK when ex_redirect=0 and ld_cnt=0.
  - ACK (1 cycle): int_ack=1, int_redirect=1, flush_ifid=1. -> HOLD.
  - HOLD: -> IDLE when ipu_int=0. Each request level is accepted once.
  - ex_halt in WAIT/ACK/HOLD: -> IDLE, no further ack; halt proceeds.
- Outputs other than forward selects depend only on FSM state plus the current-cycle hazard terms listed above.

Optional Feature:
HAZ_FWD_EN.
- Defined: forwarding as above.
- Undefined: fwd_a=fwd_b=00 always. Any valid source matching ex_rd/mem_rd/wb_rd with the matching we set stalls (stall_if=bubble_id=1) until no match. ld_cnt path still applies to EX loads.

Decomposition:
- Package hazard_pkg: fwd select encodings (FWD_RF, FWD_MEM, FWD_WB), halt/int FSM state enums, NOP constant 16'h1000.
- Sub-module hazard_fwd_sel: combinational operand selector, instantiated twice (A, B).
- FSMs and counters live in the top.

Test Plan:
- LOAD_LAT=1, ex_ld=ex_we=1, ex_rd=3, id_rs_a=3 vld -> stall_if=bubble_id=1 exactly 1 cycle. LOAD_LAT=3 -> exactly 3 cycles.
- mem_we=1 mem_rd=5, wb_we=1 wb_rd=5, id_rs_b=5 -> fwd_b=01. Set mem_ld=1 -> fwd_b=10. Source invalid -> 00.
- Load-use hit plus ex_redirect same cycle -> flush_ifid=flush_idex=1, bubble_id=0, no stall next cycle.
- ex_halt pulse, HALT_DRAIN=2 -> flushes that cycle, halted=1 on cycle 3 and stays 1. rst=0 mid-DRAIN -> all outputs 0 immediately.
- ipu_int held high during a 3-cycle load stall -> int_ack single pulse after ld_cnt=0. No second ack until ipu_int falls and rises again.
- HAZ_FWD_EN undefined, wb_we=1 wb_rd=2, id_rs_a=2 -> stall 1 cycle, fwd_a=00.
